countdown_scheduler: RTL and testbench

Shared countdown-timer controller for the alarm system. It accepts start/cancel pulses from four requesters: arm delay, driver-door delay, passenger-door delay and alarm-on duration. It holds the four reprogrammable interval values, grants the single seconds counter to the highest-priority pending request and pulses `expired` when that countdown ends. It sits between the alarm FSM and the siren generator, and also supplies the 1 Hz and 0.5 Hz enables.

---
 rtl/alarm_pkg.sv | 47 ++++
 rtl/tick_prescaler.sv | 44 ++++
 rtl/countdown_scheduler.sv | 169 ++++++++++++++++
 tb/tb_countdown_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm-system countdown scheduler.
//   - requester index constants (also the bit positions in req/cancel/grant)
//   - power-on interval values in seconds
//   - scheduler state enum
//   - highest_index():    highest set bit of a 4-bit mask (index 3 wins)
//   - default_interval(): power-on interval for a requester index
package alarm_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] ARM_DELAY       = 2'd0;
    localparam logic [1:0] DRIVER_DELAY    = 2'd1;
    localparam logic [1:0] PASSENGER_DELAY = 2'd2;
    localparam logic [1:0] ALARM_ON        = 2'd3;

    localparam logic [3:0] ARM_DELAY_DEFAULT       = 4'd6;
    localparam logic [3:0] DRIVER_DELAY_DEFAULT    = 4'd8;
    localparam logic [3:0] PASSENGER_DELAY_DEFAULT = 4'd15;
    localparam logic [3:0] ALARM_ON_DEFAULT        = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [1:0] highest_index(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bits[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] default_interval(input logic [1:0] idx);
        logic [3:0] value;
        case (idx)
            ARM_DELAY:       value = ARM_DELAY_DEFAULT;
            DRIVER_DELAY:    value = DRIVER_DELAY_DEFAULT;
            PASSENGER_DELAY: value = PASSENGER_DELAY_DEFAULT;
            default:         value = ALARM_ON_DEFAULT;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to a 1 Hz enable and a
// 0.5 Hz enable.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : synchronous restart of the cycle counter (scheduler load)
//   tick         : combinational "this edge is a 1 Hz edge" strobe for the
//                  scheduler, suppressed when clear is high
//   one_hz_en    : registered tick, one cycle every CLK_HZ cycles
//   half_hz_en   : registered, high on every second one_hz_en
// The phase bit is only cleared by reset so the 0.5 Hz cadence is not
// disturbed by scheduler restarts.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic one_hz_en,
    output logic half_hz_en
);
    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;
    logic          phase;

    assign tick = (count == LAST) && !clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            phase      <= 1'b0;
            one_hz_en  <= 1'b0;
            half_hz_en <= 1'b0;
        end else begin
            one_hz_en  <= tick;
            half_hz_en <= tick & phase;
            if (tick) phase <= ~phase;
            if (clear || (count == LAST)) count <= '0;
            else                          count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: shares one seconds counter between four countdown
// requesters (arm delay, driver door, passenger door, alarm-on duration).
//   clock, reset        : system clock, asynchronous active-high reset
//   req[3:0]            : start pulses, bit 3 has the highest priority
//   cancel[3:0]         : per-requester cancel pulses
//   reprogram, prog_sel, prog_value : write one interval-table slot
//   grant[3:0]          : one-hot owner of the counter, 0 when idle
//   busy                : countdown running (COUNT state)
//   expired             : one-cycle pulse at the end of a countdown
//   remaining[3:0]      : seconds left
//   one_hz_en, half_hz_en : shared time-base enables
//   state_dbg           : current scheduler state
// Build option: define COUNTDOWN_SCHED_PREEMPT_EN to let a higher-priority
// pending request abort a running countdown; without it the scheduler is
// strictly non-preemptive.
//
// Request protocol: req/cancel/reprogram are single-cycle pulses with no
// back-pressure. A req pulse is latched into pend and stays there until it is
// served (loaded), cancelled, or flushed by reprogram; nothing is ever lost
// except by cancel/reprogram. All outputs are registered.
module countdown_scheduler
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   cancel,
    input  logic         reprogram,
    input  logic [1:0]   prog_sel,
    input  logic [3:0]   prog_value,
    output logic [3:0]   grant,
    output logic         busy,
    output logic         expired,
    output logic [3:0]   remaining,
    output logic         one_hz_en,
    output logic         half_hz_en,
    output sched_state_t state_dbg
);
    logic [3:0]   interval [NUM_REQ];
    sched_state_t state;
    logic [3:0]   pend;
    logic [1:0]   owner;
    logic         tick;
    logic [1:0]   top_idx;
    logic         owner_cancel;
    logic         final_tick;
    logic         preempt_hit;
    logic         load_en;
    logic [1:0]   load_idx;
    logic [3:0]   load_mask;
    logic [3:0]   load_value;

    assign state_dbg    = state;
    assign top_idx      = highest_index(pend);
    assign owner_cancel = cancel[owner];
    assign final_tick   = tick && (remaining == 4'd1);

`ifdef COUNTDOWN_SCHED_PREEMPT_EN
    assign preempt_hit = (|pend) && (top_idx > owner);
`else
    assign preempt_hit = 1'b0;
`endif

    // A load covers a fresh grant from IDLE, a preemption and a retrigger of
    // the current owner; all three restart the prescaler at the load edge.
    // Cancel and expiry of the owner take precedence over any load in COUNT.
    always_comb begin
        load_en  = 1'b0;
        load_idx = top_idx;
        if (!reprogram) begin
            case (state)
                IDLE: load_en = |pend;
                COUNT: begin
                    if (!owner_cancel && !final_tick) begin
                        if (preempt_hit) begin
                            load_en = 1'b1;
                        end else if (pend[owner]) begin
                            load_en  = 1'b1;
                            load_idx = owner;
                        end
                    end
                end
                default: load_en = 1'b0;
            endcase
        end
    end

    assign load_mask  = load_en ? (4'b0001 << load_idx) : 4'b0000;
    assign load_value = interval[load_idx];

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clock     (clock),
        .reset     (reset),
        .clear     (load_en),
        .tick      (tick),
        .one_hz_en (one_hz_en),
        .half_hz_en(half_hz_en)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= 4'b0000;
            owner     <= 2'd0;
            grant     <= 4'b0000;
            busy      <= 1'b0;
            expired   <= 1'b0;
            remaining <= 4'd0;
            for (int i = 0; i < NUM_REQ; i++) begin
                interval[i] <= default_interval(2'(i));
            end
        end else begin
            expired <= 1'b0;

            // A new req for the slot being loaded survives so it can retrigger.
            if (reprogram) pend <= 4'b0000;
            else           pend <= ((pend & ~load_mask) | req) & ~cancel;

            if (reprogram) begin
                interval[prog_sel] <= prog_value;
                state     <= IDLE;
                grant     <= 4'b0000;
                busy      <= 1'b0;
                remaining <= 4'd0;
            end else if (load_en) begin
                owner     <= load_idx;
                grant     <= 4'b0001 << load_idx;
                remaining <= load_value;
                if (load_value == 4'd0) begin
                    // Zero interval: expire on the cycle right after the load.
                    state   <= DONE;
                    busy    <= 1'b0;
                    expired <= 1'b1;
                end else begin
                    state <= COUNT;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    COUNT: begin
                        if (owner_cancel) begin
                            state     <= IDLE;
                            grant     <= 4'b0000;
                            busy      <= 1'b0;
                            remaining <= 4'd0;
                        end else if (final_tick) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            expired   <= 1'b1;
                            remaining <= 4'd0;
                        end else if (tick) begin
                            remaining <= remaining - 4'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        grant <= 4'b0000;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_scheduler.sv
// Bench for countdown_scheduler at CLK_HZ = 4. Expected expiries (owner and
// load-to-expired latency) are queued when requests are driven and checked
// when the DUT pulses expired; directed checks cover reset, grant/remaining
// after loads, cancel, reprogram abort and asynchronous reset.
module tb_countdown_scheduler;
    import alarm_pkg::*;

    localparam int CLK_HZ = 4;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   cancel;
    logic         reprogram;
    logic [1:0]   prog_sel;
    logic [3:0]   prog_value;
    logic [3:0]   grant;
    logic         busy;
    logic         expired;
    logic [3:0]   remaining;
    logic         one_hz_en;
    logic         half_hz_en;
    sched_state_t state_dbg;

    countdown_scheduler #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .cancel    (cancel),
        .reprogram (reprogram),
        .prog_sel  (prog_sel),
        .prog_value(prog_value),
        .grant     (grant),
        .busy      (busy),
        .expired   (expired),
        .remaining (remaining),
        .one_hz_en (one_hz_en),
        .half_hz_en(half_hz_en),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    // entry = {grant at expiry, load-to-expired latency in cycles}
    logic [15:0] exp_q[$];
    logic [3:0]  model_table [4];
    int          exp_seen = 0;
    int          load_cyc = 0;
    logic [3:0]  prev_grant = 4'b0000;
    logic [3:0]  prev_rem   = 4'd0;

    task automatic model_reset();
        model_table[0] = 4'd6;
        model_table[1] = 4'd8;
        model_table[2] = 4'd15;
        model_table[3] = 4'd10;
    endtask

    always @(negedge clock) begin
        logic [15:0] entry;
        if (reset) begin
            prev_grant = 4'b0000;
            prev_rem   = 4'd0;
        end else begin
            // A load shows up as a new owner or as remaining jumping upward.
            if (((grant != prev_grant) && (grant != 4'b0000)) || (remaining > prev_rem))
                load_cyc = cyc;
            if (expired) begin
                exp_seen++;
                check("expired_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    entry = exp_q.pop_front();
                    check("expired_grant", 32'(grant), 32'(entry[15:12]));
                    check("expired_latency", 32'(cyc - load_cyc), 32'(entry[11:0]));
                end
            end
            prev_grant = grant;
            prev_rem   = remaining;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_req(input logic [3:0] mask, input bit expect_expiry);
        logic [3:0] g;
        if (expect_expiry) begin
            for (int i = 3; i >= 0; i--) begin
                if (mask[i]) begin
                    g = 4'b0001 << i;
                    exp_q.push_back({g, 12'(int'(model_table[i]) * CLK_HZ)});
                end
            end
        end
        @(negedge clock);
        req = mask;
        @(negedge clock);
        req = 4'b0000;
    endtask

    task automatic pulse_cancel(input logic [3:0] mask);
        @(negedge clock);
        cancel = mask;
        @(negedge clock);
        cancel = 4'b0000;
    endtask

    task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] value);
        @(negedge clock);
        reprogram  = 1'b1;
        prog_sel   = sel;
        prog_value = value;
        model_table[sel] = value;
        @(negedge clock);
        reprogram = 1'b0;
    endtask

    task automatic wait_expired(input int budget);
        int start;
        int n;
        start = exp_seen;
        n = 0;
        while ((exp_seen == start) && (n < budget)) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("expired_timeout", 32'(exp_seen != start), 1);
    endtask

    task automatic wait_remaining(input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while ((remaining != target) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        check("reach_remaining", 32'(remaining), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         n;
        int         period;
        logic       half_a;
        logic [3:0] rnd_val;

        req        = 4'b0000;
        cancel     = 4'b0000;
        reprogram  = 1'b0;
        prog_sel   = 2'd0;
        prog_value = 4'd0;
        model_reset();

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_one_hz", 32'(one_hz_en), 0);
        check("rst_half_hz", 32'(half_hz_en), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;

        // Time base: period CLK_HZ, half_hz on every second tick.
        n = 0;
        while (!one_hz_en && n < 10) begin @(negedge clock); n++; end
        check("first_tick_seen", 32'(one_hz_en), 1);
        half_a = half_hz_en;
        @(negedge clock);
        check("tick_one_cycle", 32'(one_hz_en), 0);
        period = 1;
        while (!one_hz_en && period < 10) begin @(negedge clock); period++; end
        check("tick_period", 32'(period), CLK_HZ);
        check("half_first", 32'(half_a), 0);
        check("half_second", 32'(half_hz_en), 1);

        // Arm delay: 6 s countdown.
        pulse_req(4'b0001, 1'b1);
        @(negedge clock);
        check("arm_grant", 32'(grant), 32'b0001);
        check("arm_busy", 32'(busy), 1);
        check("arm_remaining", 32'(remaining), 6);
        for (int s = 5; s >= 1; s--) begin
            repeat (CLK_HZ) @(negedge clock);
            check("arm_countdown", 32'(remaining), 32'(s));
        end
        wait_expired(20);
        @(negedge clock);
        check("arm_grant_released", 32'(grant), 0);
        check("arm_idle", 32'(state_dbg), 32'(IDLE));

        // Reprogram: slot 2 to 3 s, slot 1 to 0 s.
        do_reprogram(PASSENGER_DELAY, 4'd3);
        pulse_req(4'b0100, 1'b1);
        wait_expired(40);
        repeat (2) @(negedge clock);
        do_reprogram(DRIVER_DELAY, 4'd0);
        pulse_req(4'b0010, 1'b1);
        @(negedge clock);
        check("zero_grant", 32'(grant), 32'b0010);
        check("zero_expired_now", 32'(expired), 1);
        check("zero_not_busy", 32'(busy), 0);
        wait_expired(5);
        repeat (2) @(negedge clock);
        do_reprogram(DRIVER_DELAY, 4'd8);
        do_reprogram(PASSENGER_DELAY, 4'd15);

        // Simultaneous requests: passenger first, then driver.
        pulse_req(4'b0110, 1'b1);
        @(negedge clock);
        check("simul_first_grant", 32'(grant), 32'b0100);
        check("simul_first_remaining", 32'(remaining), 15);
        wait_expired(80);
        wait_expired(60);
        repeat (3) @(negedge clock);

        // Preemption attempt by ALARM_ON during DRIVER at remaining = 5.
`ifdef COUNTDOWN_SCHED_PREEMPT_EN
        pulse_req(4'b0010, 1'b0);
        wait_remaining(4'd5, 40);
        pulse_req(4'b1000, 1'b1);
        @(negedge clock);
        check("preempt_grant", 32'(grant), 32'b1000);
        check("preempt_remaining", 32'(remaining), 10);
        wait_expired(60);
`else
        pulse_req(4'b0010, 1'b1);
        wait_remaining(4'd5, 40);
        pulse_req(4'b1000, 1'b1);
        @(negedge clock);
        check("nopreempt_grant", 32'(grant), 32'b0010);
        check("nopreempt_busy", 32'(busy), 1);
        wait_expired(40);
        wait_expired(60);
`endif
        repeat (3) @(negedge clock);

        // Cancel mid-count: no expiry, back to idle.
        pulse_req(4'b0001, 1'b0);
        repeat (6) @(negedge clock);
        pulse_cancel(4'b0001);
        check("cancel_grant", 32'(grant), 0);
        check("cancel_busy", 32'(busy), 0);
        repeat (30) @(negedge clock);
        check("cancel_stays_idle", 32'(grant), 0);

        // Retrigger at remaining = 2 reloads 6 s and restarts the prescaler.
        pulse_req(4'b0001, 1'b1);
        @(negedge clock);
        wait_remaining(4'd2, 40);
        pulse_req(4'b0001, 1'b0);
        @(negedge clock);
        check("retrig_remaining", 32'(remaining), 6);
        check("retrig_grant", 32'(grant), 32'b0001);
        wait_expired(40);
        repeat (3) @(negedge clock);

        // Reprogram during ALARM_ON aborts and flushes pending requests.
        pulse_req(4'b1000, 1'b0);
        repeat (8) @(negedge clock);
        pulse_req(4'b0001, 1'b0);
        do_reprogram(ALARM_ON, 4'd10);
        check("reprog_abort_grant", 32'(grant), 0);
        check("reprog_abort_busy", 32'(busy), 0);
        check("reprog_abort_state", 32'(state_dbg), 32'(IDLE));
        repeat (12) @(negedge clock);
        check("reprog_pend_flushed", 32'(grant), 0);

        // Random interval on slot 0.
        rnd_val = 4'($urandom_range(1, 5));
        do_reprogram(ARM_DELAY, rnd_val);
        pulse_req(4'b0001, 1'b1);
        @(negedge clock);
        check("rand_remaining", 32'(remaining), 32'(rnd_val));
        wait_expired(40);
        repeat (3) @(negedge clock);

        // Asynchronous reset mid-count restores defaults.
        do_reprogram(ARM_DELAY, 4'd3);
        pulse_req(4'b0100, 1'b0);
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_remaining", 32'(remaining), 0);
        check("async_rst_expired", 32'(expired), 0);
        check("async_rst_one_hz", 32'(one_hz_en), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        pulse_req(4'b0001, 1'b1);
        @(negedge clock);
        check("post_rst_arm_default", 32'(remaining), 6);
        wait_expired(40);
        pulse_req(4'b0100, 1'b0);
        @(negedge clock);
        check("post_rst_pass_default", 32'(remaining), 15);
        pulse_cancel(4'b0100);

        repeat (5) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
